// File: rtl/fifo_sync_flops_if.sv
// Bus-side handshake bundle for fifo_sync_flops: push/pop requests, write data,
// show-ahead head word, occupancy and error pulses.
interface fifo_sync_flops_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push_i;
  logic [WIDTH-1:0] d_i;
  logic             pop_i;
  logic [WIDTH-1:0] q_o;
  logic             full_o;
  logic             empty_o;
  logic [CW-1:0]    count_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output push_i, d_i, pop_i,
    input  q_o, full_o, empty_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, d_i, pop_i,
    output q_o, full_o, empty_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_sync_flops.sv
// Synchronous flop-based FIFO with show-ahead head, count-decoded flags and
// registered one-cycle overflow/underflow pulses. Rows reset to all-ones.
module fifo_sync_flops #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fifo_sync_flops_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO still succeeds when a pop frees the head slot.
  always_comb begin
    pop_ok  = bus.pop_i && (count != '0);
    push_ok = bus.push_i && ((count < DEPTH_C) || pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '1;
      end
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wp] <= bus.d_i;
        wp      <= (wp == LAST_P) ? '0 : wp + 1'b1;
      end
      if (pop_ok) begin
        rp <= (rp == LAST_P) ? '0 : rp + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= bus.push_i && !push_ok;
      underflow <= bus.pop_i && !pop_ok;
    end
  end

  always_comb begin
    bus.q_o         = (count != '0) ? mem[rp] : '1;
    bus.full_o      = (count == DEPTH_C);
    bus.empty_o     = (count == '0);
    bus.count_o     = count;
    bus.overflow_o  = overflow;
    bus.underflow_o = underflow;
  end
endmodule

// File: tb/tb_fifo_sync_flops.sv
// Directed bench for fifo_sync_flops (WIDTH=4, DEPTH=8): fill/drain, wrap,
// simultaneous push+pop at both boundaries, error pulses and async reset.
module tb_fifo_sync_flops;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   check_cnt;

  fifo_sync_flops_if #(.WIDTH(4), .DEPTH(8)) bus ();

  fifo_sync_flops #(.WIDTH(4), .DEPTH(8)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push_i = 1'b0;
    bus.pop_i  = 1'b0;
    bus.d_i    = 4'h0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    check_cnt++;
    if (bus.q_o !== 4'hF) $display("FAIL reset_q got=%h exp=F", bus.q_o); else pass_cnt++;
    check_cnt++;
    if (bus.empty_o !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.empty_o); else pass_cnt++;
    check_cnt++;
    if (bus.full_o !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.full_o); else pass_cnt++;
    check_cnt++;
    if (bus.count_o !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count_o); else pass_cnt++;
    check_cnt++;
    if ({bus.overflow_o, bus.underflow_o} !== 2'b00)
      $display("FAIL reset_err got=%b exp=00", {bus.overflow_o, bus.underflow_o}); else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      bus.push_i = 1'b1;
      bus.d_i    = 4'(i);
      tick();
      check_cnt++;
      if (bus.count_o !== 4'(i)) $display("FAIL fill_count got=%0d exp=%0d", bus.count_o, i); else pass_cnt++;
      check_cnt++;
      if (bus.full_o !== (i == 8)) $display("FAIL fill_full got=%b exp=%b", bus.full_o, (i == 8)); else pass_cnt++;
    end
    bus.d_i = 4'hA;
    tick();
    check_cnt++;
    if (bus.overflow_o !== 1'b1) $display("FAIL ovf_pulse got=%b exp=1", bus.overflow_o); else pass_cnt++;
    check_cnt++;
    if (bus.count_o !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", bus.count_o); else pass_cnt++;
    check_cnt++;
    if (bus.q_o !== 4'h1) $display("FAIL ovf_head got=%h exp=1", bus.q_o); else pass_cnt++;
    idle();
    tick();
    check_cnt++;
    if (bus.overflow_o !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", bus.overflow_o); else pass_cnt++;
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 8; i++) begin
      check_cnt++;
      if (bus.q_o !== 4'(i)) $display("FAIL drain_q got=%h exp=%h", bus.q_o, 4'(i)); else pass_cnt++;
      bus.pop_i = 1'b1;
      tick();
      check_cnt++;
      if (bus.count_o !== 4'(8 - i)) $display("FAIL drain_count got=%0d exp=%0d", bus.count_o, 8 - i); else pass_cnt++;
    end
    check_cnt++;
    if (bus.empty_o !== 1'b1) $display("FAIL drain_empty got=%b exp=1", bus.empty_o); else pass_cnt++;
    check_cnt++;
    if (bus.q_o !== 4'hF) $display("FAIL drain_qF got=%h exp=F", bus.q_o); else pass_cnt++;
    tick();
    check_cnt++;
    if (bus.underflow_o !== 1'b1) $display("FAIL udf_pulse got=%b exp=1", bus.underflow_o); else pass_cnt++;
    check_cnt++;
    if (bus.count_o !== 4'd0) $display("FAIL udf_count got=%0d exp=0", bus.count_o); else pass_cnt++;
    idle();
    tick();
    check_cnt++;
    if (bus.underflow_o !== 1'b0) $display("FAIL udf_clear got=%b exp=0", bus.underflow_o); else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      bus.push_i = 1'b1;
      bus.d_i    = 4'(8 + i);
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      check_cnt++;
      if (bus.q_o !== 4'(8 + i)) $display("FAIL wrap_pre_q got=%h exp=%h", bus.q_o, 4'(8 + i)); else pass_cnt++;
      bus.pop_i = 1'b1;
      tick();
    end
    idle();
    for (int i = 3; i <= 7; i++) begin
      bus.push_i = 1'b1;
      bus.d_i    = 4'(i);
      tick();
    end
    idle();
    check_cnt++;
    if (bus.count_o !== 4'd5) $display("FAIL wrap_count got=%0d exp=5", bus.count_o); else pass_cnt++;
    for (int i = 3; i <= 7; i++) begin
      check_cnt++;
      if (bus.q_o !== 4'(i)) $display("FAIL wrap_q got=%h exp=%h", bus.q_o, 4'(i)); else pass_cnt++;
      bus.pop_i = 1'b1;
      tick();
    end
    idle();
    check_cnt++;
    if (bus.empty_o !== 1'b1) $display("FAIL wrap_empty got=%b exp=1", bus.empty_o); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_q [8];
    for (int i = 1; i <= 8; i++) begin
      bus.push_i = 1'b1;
      bus.d_i    = 4'(i);
      tick();
    end
    bus.pop_i = 1'b1;
    bus.d_i   = 4'hC;
    tick();
    idle();
    check_cnt++;
    if (bus.overflow_o !== 1'b0) $display("FAIL fpp_ovf got=%b exp=0", bus.overflow_o); else pass_cnt++;
    check_cnt++;
    if (bus.count_o !== 4'd8) $display("FAIL fpp_count got=%0d exp=8", bus.count_o); else pass_cnt++;
    exp_q = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC};
    for (int i = 0; i < 8; i++) begin
      check_cnt++;
      if (bus.q_o !== exp_q[i]) $display("FAIL fpp_q[%0d] got=%h exp=%h", i, bus.q_o, exp_q[i]); else pass_cnt++;
      bus.pop_i = 1'b1;
      tick();
    end
    idle();
  endtask

  task automatic test_empty_push_pop();
    bus.push_i = 1'b1;
    bus.pop_i  = 1'b1;
    bus.d_i    = 4'h5;
    tick();
    idle();
    check_cnt++;
    if (bus.underflow_o !== 1'b1) $display("FAIL epp_udf got=%b exp=1", bus.underflow_o); else pass_cnt++;
    check_cnt++;
    if (bus.count_o !== 4'd1) $display("FAIL epp_count got=%0d exp=1", bus.count_o); else pass_cnt++;
    check_cnt++;
    if (bus.q_o !== 4'h5) $display("FAIL epp_q got=%h exp=5", bus.q_o); else pass_cnt++;
    check_cnt++;
    if (bus.empty_o !== 1'b0) $display("FAIL epp_empty got=%b exp=0", bus.empty_o); else pass_cnt++;
    tick();
    check_cnt++;
    if (bus.underflow_o !== 1'b0) $display("FAIL epp_udf_clear got=%b exp=0", bus.underflow_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      bus.push_i = 1'b1;
      bus.d_i    = 4'(i);
      tick();
    end
    // Drop reset mid-cycle while a push is still pending.
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (bus.count_o !== 4'd0) $display("FAIL areset_count got=%0d exp=0", bus.count_o); else pass_cnt++;
    check_cnt++;
    if (bus.q_o !== 4'hF) $display("FAIL areset_q got=%h exp=F", bus.q_o); else pass_cnt++;
    check_cnt++;
    if (bus.empty_o !== 1'b1) $display("FAIL areset_empty got=%b exp=1", bus.empty_o); else pass_cnt++;
    tick();
    check_cnt++;
    if (bus.count_o !== 4'd0) $display("FAIL areset_hold got=%0d exp=0", bus.count_o); else pass_cnt++;
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    check_cnt = 0;
    rst_n     = 1'b1;
    idle();
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_full_push_pop();
    test_empty_push_pop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
